// File: rtl/synapse_config_loader.sv
// ----------------------------------------------------------------------------
// synapse_config_loader
//
// Host-side programmer for a serial configuration chain of N_SYN cascaded
// synapses. The host fills a local parameter file (El, gl_jump, tau_gl per
// synapse). A start pulse shifts the file into the chain head using a
// cfg_data_clk derived from clk. In verify mode the stream is sent twice, and
// on the second pass each word returning at the chain tail is compared with
// the word that was sent.
//
// Ports
//   clk            system clock
//   reset          synchronous active-low reset
//   wr_en          parameter write strobe (honoured in IDLE only)
//   wr_syn         target synapse index
//   wr_sel         0=El, 1=gl_jump, 2=tau_gl, 3=ignored
//   wr_data        write data
//   start          begin programming (single-cycle pulse)
//   verify         sampled with start; 1 = program then verify pass
//   busy           programming in progress
//   done           one-cycle pulse at completion
//   error          sticky verify mismatch flag
//   mismatch_cnt   saturating count of verify mismatches
//   cfg_data_clk   shift clock to the chain head
//   cfg_data_out   config data to the chain head
//   cfg_data_in    config data from the chain tail
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; parameter file writable
// LOW    | cfg_data_clk low, word(w) driven; verify sample on the last cycle
// HIGH   | cfg_data_clk high, word(w) held across the rising edge
// DONE   | one-cycle done pulse, then back to IDLE
// ----------------------------------------------------------------------------
module synapse_config_loader #(
   parameter int N_SYN      = 4,
   parameter int WORD_WIDTH = 16,
   parameter int CLK_DIV    = 2
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        wr_en,
   input  logic [((N_SYN > 1) ? $clog2(N_SYN) : 1)-1:0] wr_syn,
   input  logic [1:0]                                  wr_sel,
   input  logic [WORD_WIDTH-1:0]                       wr_data,
   input  logic                                        start,
   input  logic                                        verify,
   output logic                                        busy,
   output logic                                        done,
   output logic                                        error,
   output logic [15:0]                                 mismatch_cnt,
   output logic                                        cfg_data_clk,
   output logic [WORD_WIDTH-1:0]                       cfg_data_out,
   input  logic [WORD_WIDTH-1:0]                       cfg_data_in
);

   localparam int SYN_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;
   localparam int L     = 4 * N_SYN;
   localparam int W_W   = $clog2(L);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [W_W-1:0]   W_LAST   = W_W'(L - 1);
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [SYN_W:0]   SYN_LIM  = (SYN_W + 1)'(N_SYN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [W_W-1:0]   w, w_nxt;
   logic             pass, pass_nxt;
   logic             two_pass, two_pass_nxt;
   logic [DIV_W-1:0] div_cnt, div_nxt;
   logic             div_tc;

   logic [WORD_WIDTH-1:0] el_q  [N_SYN];
   logic [WORD_WIDTH-1:0] gl_q  [N_SYN];
   logic [WORD_WIDTH-1:0] tau_q [N_SYN];

   logic [WORD_WIDTH-1:0] data_q;
   logic                  error_q;
   logic [15:0]           mism_q;

   logic wr_ok;
   logic accept;
   logic sample;

   // Stream word idx: the first word lands at the tail, so the last synapse
   // goes first, and within a synapse the pass-register dummy leads.
   function automatic logic [WORD_WIDTH-1:0] word_of(input logic [W_W-1:0] idx);
      logic [SYN_W-1:0] syn;
      syn = SYN_W'(N_SYN - 1) - SYN_W'(idx >> 2);
      case (idx[1:0])
         2'd1:    word_of = tau_q[syn];
         2'd2:    word_of = gl_q[syn];
         2'd3:    word_of = el_q[syn];
         default: word_of = '0;
      endcase
   endfunction

   assign div_tc = (div_cnt == '0);
   assign wr_ok  = (state == S_IDLE) && wr_en && (wr_sel != 2'd3) &&
                   ({1'b0, wr_syn} < SYN_LIM);
   assign accept = (state == S_IDLE) && start;
   // Tail is sampled just before the rising edge of the word being compared.
   assign sample = (state == S_LOW) && div_tc && pass;

   always_comb begin
      state_nxt    = state;
      w_nxt        = w;
      pass_nxt     = pass;
      two_pass_nxt = two_pass;
      div_nxt      = div_cnt;
      busy         = 1'b0;
      done         = 1'b0;
      cfg_data_clk = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt    = S_LOW;
               w_nxt        = '0;
               pass_nxt     = 1'b0;
               two_pass_nxt = verify;
               div_nxt      = DIV_LOAD;
            end
         end
         S_LOW: begin
            busy = 1'b1;
            if (div_tc) begin
               state_nxt = S_HIGH;
               div_nxt   = DIV_LOAD;
            end else begin
               div_nxt = div_cnt - DIV_W'(1);
            end
         end
         S_HIGH: begin
            busy         = 1'b1;
            cfg_data_clk = 1'b1;
            if (div_tc) begin
               div_nxt = DIV_LOAD;
               if (w != W_LAST) begin
                  w_nxt     = w + W_W'(1);
                  state_nxt = S_LOW;
               end else if (two_pass && !pass) begin
                  w_nxt     = '0;
                  pass_nxt  = 1'b1;
                  state_nxt = S_LOW;
               end else begin
                  state_nxt = S_DONE;
               end
            end else begin
               div_nxt = div_cnt - DIV_W'(1);
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         w        <= '0;
         pass     <= 1'b0;
         two_pass <= 1'b0;
         div_cnt  <= '0;
         data_q   <= '0;
         error_q  <= 1'b0;
         mism_q   <= '0;
         for (int i = 0; i < N_SYN; i++) begin
            el_q[i]  <= '0;
            gl_q[i]  <= '0;
            tau_q[i] <= '0;
         end
      end else begin
         state    <= state_nxt;
         w        <= w_nxt;
         pass     <= pass_nxt;
         two_pass <= two_pass_nxt;
         div_cnt  <= div_nxt;

         // Data is loaded on entry to each LOW phase so it is settled for the
         // whole word and stays put through HIGH and DONE.
         if (state_nxt == S_LOW)
            data_q <= word_of(w_nxt);

         if (wr_ok) begin
            case (wr_sel)
               2'd0:    el_q[wr_syn]  <= wr_data;
               2'd1:    gl_q[wr_syn]  <= wr_data;
               2'd2:    tau_q[wr_syn] <= wr_data;
               default: ;
            endcase
         end

         if (accept) begin
            error_q <= 1'b0;
            mism_q  <= '0;
         end else if (sample && (cfg_data_in != data_q)) begin
            error_q <= 1'b1;
            if (mism_q != 16'hFFFF)
               mism_q <= mism_q + 16'd1;
         end
      end
   end

   assign cfg_data_out = data_q;
   assign error        = error_q;
   assign mismatch_cnt = mism_q;

endmodule

// File: tb/tb_synapse_config_loader.sv
module tb_synapse_config_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        wr_en_a, start_a, verify_a;
   logic [1:0]  wr_syn_a, wr_sel_a;
   logic [15:0] wr_data_a;
   logic        busy_a, done_a, error_a, dclk_a;
   logic [15:0] mism_a, dout_a, din_a;

   logic        wr_en_b, start_b, verify_b;
   logic [0:0]  wr_syn_b;
   logic [1:0]  wr_sel_b;
   logic [15:0] wr_data_b;
   logic        busy_b, done_b, error_b, dclk_b;
   logic [15:0] mism_b, dout_b, din_b;

   synapse_config_loader #(.N_SYN(4), .WORD_WIDTH(16), .CLK_DIV(2)) dut_a (
      .clk(clk), .reset(reset), .wr_en(wr_en_a), .wr_syn(wr_syn_a),
      .wr_sel(wr_sel_a), .wr_data(wr_data_a), .start(start_a), .verify(verify_a),
      .busy(busy_a), .done(done_a), .error(error_a), .mismatch_cnt(mism_a),
      .cfg_data_clk(dclk_a), .cfg_data_out(dout_a), .cfg_data_in(din_a));

   synapse_config_loader #(.N_SYN(1), .WORD_WIDTH(16), .CLK_DIV(1)) dut_b (
      .clk(clk), .reset(reset), .wr_en(wr_en_b), .wr_syn(wr_syn_b),
      .wr_sel(wr_sel_b), .wr_data(wr_data_b), .start(start_b), .verify(verify_b),
      .busy(busy_b), .done(done_b), .error(error_b), .mismatch_cnt(mism_b),
      .cfg_data_clk(dclk_b), .cfg_data_out(dout_b), .cfg_data_in(din_b));

   // Chain models: stage index 4*s+k, k = 0 El, 1 gl_jump, 2 tau_gl, 3 pass.
   logic [15:0] chain_a [16] = '{default: 16'h0};
   logic [15:0] chain_b [4]  = '{default: 16'h0};
   logic        stuck_a = 1'b0;

   assign din_a = stuck_a ? 16'hFFFF : chain_a[15];
   assign din_b = chain_b[3];

   always @(posedge dclk_a) begin
      for (int i = 15; i > 0; i--) chain_a[i] <= chain_a[i-1];
      chain_a[0] <= dout_a;
   end

   always @(posedge dclk_b) begin
      for (int i = 3; i > 0; i--) chain_b[i] <= chain_b[i-1];
      chain_b[0] <= dout_b;
   end

   // Reference parameter file, index [instance][synapse].
   logic [15:0] m_el  [2][4];
   logic [15:0] m_gl  [2][4];
   logic [15:0] m_tau [2][4];

   int total = 0;
   int bad   = 0;
   logic [15:0] q_a [$];
   logic [15:0] q_b [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors: one expected word per rising cfg_data_clk.
   logic prev_a = 1'b0;
   logic prev_b = 1'b0;

   always @(negedge clk) begin
      if (dclk_a && !prev_a) begin
         if (q_a.size() == 0) begin
            total++; bad++;
            $display("FAIL a_edge: extra cfg_data_clk edge, data=%h expected no edge", dout_a);
         end else begin
            check("a_word", 32'(dout_a), 32'(q_a.pop_front()));
         end
      end
      prev_a = dclk_a;
   end

   always @(negedge clk) begin
      if (dclk_b && !prev_b) begin
         if (q_b.size() == 0) begin
            total++; bad++;
            $display("FAIL b_edge: extra cfg_data_clk edge, data=%h expected no edge", dout_b);
         end else begin
            check("b_word", 32'(dout_b), 32'(q_b.pop_front()));
         end
      end
      prev_b = dclk_b;
   end

   function automatic logic [15:0] exp_word(input int inst, input int w);
      int n, syn, slot;
      n    = (inst == 0) ? 4 : 1;
      syn  = n - 1 - w / 4;
      slot = 3 - w % 4;
      case (slot)
         0:       return m_el[inst][syn];
         1:       return m_gl[inst][syn];
         2:       return m_tau[inst][syn];
         default: return 16'h0;
      endcase
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 2; i++)
         for (int s = 0; s < 4; s++) begin
            m_el[i][s] = 16'h0; m_gl[i][s] = 16'h0; m_tau[i][s] = 16'h0;
         end
   endtask

   task automatic model_wr(input int inst, input int syn, input int sel, input logic [15:0] d);
      int n;
      n = (inst == 0) ? 4 : 1;
      if (syn < n) begin
         case (sel)
            0:       m_el[inst][syn]  = d;
            1:       m_gl[inst][syn]  = d;
            2:       m_tau[inst][syn] = d;
            default: ;
         endcase
      end
   endtask

   task automatic drive(input int inst, input logic st, input logic v, input logic we,
                        input int syn, input int sel, input logic [15:0] d);
      if (inst == 0) begin
         start_a = st; verify_a = v; wr_en_a = we;
         wr_syn_a = 2'(syn); wr_sel_a = 2'(sel); wr_data_a = d;
      end else begin
         start_b = st; verify_b = v; wr_en_b = we;
         wr_syn_b = 1'(syn); wr_sel_b = 2'(sel); wr_data_b = d;
      end
   endtask

   task automatic wr(input int inst, input int syn, input int sel, input logic [15:0] d);
      drive(inst, 1'b0, 1'b0, 1'b1, syn, sel, d);
      model_wr(inst, syn, sel, d);
      @(posedge clk); #1;
      drive(inst, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0);
   endtask

   // One programming run. inj: cycle at which start+wr_en are pulsed while
   // busy (-1 = none). ws_en: write syn0 El in the same cycle as start.
   task automatic run(input int inst, input logic v, input int exp_cyc, input int inj,
                      input logic ws_en, input logic [15:0] ws_data, input string tag);
      int n, passes, cyc;
      logic dn, bz, busy_ok, got;
      n = (inst == 0) ? 4 : 1;
      passes = v ? 2 : 1;
      if (ws_en) model_wr(inst, 0, 0, ws_data);
      for (int p = 0; p < passes; p++)
         for (int w = 0; w < 4 * n; w++)
            if (inst == 0) q_a.push_back(exp_word(inst, w));
            else           q_b.push_back(exp_word(inst, w));
      drive(inst, 1'b1, v, ws_en, 0, 0, ws_data);
      cyc = 0; busy_ok = 1'b1; got = 1'b0; bz = 1'b0;
      while (!got && cyc < exp_cyc + 20) begin
         @(posedge clk); #1;
         cyc++;
         drive(inst, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0);
         if (cyc == inj) drive(inst, 1'b1, 1'b0, 1'b1, 0, 0, 16'hDEAD);
         dn = (inst == 0) ? done_a : done_b;
         bz = (inst == 0) ? busy_a : busy_b;
         if (cyc == 1) begin
            check({tag, "_err_clr"},  32'((inst == 0) ? error_a : error_b), 32'd0);
            check({tag, "_mism_clr"}, 32'((inst == 0) ? mism_a : mism_b), 32'd0);
         end
         if (dn) got = 1'b1;
         else if (!bz) busy_ok = 1'b0;
      end
      check({tag, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
      check({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
      check({tag, "_busy_done"}, 32'(bz), 32'd0);
      check({tag, "_stream_left"}, 32'((inst == 0) ? q_a.size() : q_b.size()), 32'd0);
      if (inst == 0) q_a.delete(); else q_b.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      int cyc;
      logic v;
      reset = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0);
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",  32'(busy_a), 32'd0);
      check("rst_done",  32'(done_a), 32'd0);
      check("rst_error", 32'(error_a), 32'd0);
      check("rst_mism",  32'(mism_a), 32'd0);
      check("rst_dclk",  32'(dclk_a), 32'd0);
      check("rst_dout",  32'(dout_a), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Plan 1: fixed file, single pass.
      for (int s = 0; s < 4; s++) begin
         wr(0, s, 0, 16'h0100 + 16'(s));
         wr(0, s, 1, 16'h0200 + 16'(s));
         wr(0, s, 2, 16'h0300 + 16'(s));
      end
      run(0, 1'b0, 65, -1, 1'b0, 16'h0, "t1");

      // Plan 2: verify pass against the chain model.
      run(0, 1'b1, 129, -1, 1'b0, 16'h0, "t2");
      for (int s = 0; s < 4; s++) begin
         check("t2_chain_el",  32'(chain_a[4*s]),   32'(16'h0100 + 16'(s)));
         check("t2_chain_gl",  32'(chain_a[4*s+1]), 32'(16'h0200 + 16'(s)));
         check("t2_chain_tau", 32'(chain_a[4*s+2]), 32'(16'h0300 + 16'(s)));
      end
      check("t2_error", 32'(error_a), 32'd0);
      check("t2_mism",  32'(mism_a), 32'd0);

      // Plan 3: stuck tail, then a clean start clears the flags.
      stuck_a = 1'b1;
      run(0, 1'b1, 129, -1, 1'b0, 16'h0, "t3");
      check("t3_error", 32'(error_a), 32'd1);
      check("t3_mism",  32'(mism_a), 32'd16);
      stuck_a = 1'b0;
      run(0, 1'b0, 65, -1, 1'b0, 16'h0, "t3_clr");
      check("t3_error_after", 32'(error_a), 32'd0);

      // Plan 4: start/write while busy are dropped; same-cycle write+start lands.
      run(0, 1'b0, 65, 20, 1'b0, 16'h0, "t4_inj");
      run(0, 1'b0, 65, -1, 1'b0, 16'h0, "t4_after");
      run(0, 1'b0, 65, -1, 1'b1, 16'hBEEF, "t4_ws");

      // Plan 5: reset during the first HIGH phase.
      q_a.push_back(exp_word(0, 0));
      drive(0, 1'b1, 1'b0, 1'b0, 0, 0, 16'h0);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0);
      cyc = 0;
      while (!dclk_a && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("t5_reach_high", 32'(dclk_a), 32'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check("t5_dclk", 32'(dclk_a), 32'd0);
      check("t5_busy", 32'(busy_a), 32'd0);
      check("t5_dout", 32'(dout_a), 32'd0);
      q_a.delete();
      model_clear();
      @(posedge clk); #1;
      run(0, 1'b0, 65, -1, 1'b0, 16'h0, "t5_zero");

      // Plan 6: single synapse, CLK_DIV=1, verify; wr_sel=3 is a no-op.
      wr(1, 0, 0, 16'h00A1);
      wr(1, 0, 1, 16'h00B2);
      wr(1, 0, 2, 16'h00C3);
      wr(1, 0, 3, 16'h1234);
      run(1, 1'b1, 17, -1, 1'b0, 16'h0, "t6");
      check("t6_chain_el",  32'(chain_b[0]), 32'h00A1);
      check("t6_chain_gl",  32'(chain_b[1]), 32'h00B2);
      check("t6_chain_tau", 32'(chain_b[2]), 32'h00C3);
      check("t6_error", 32'(error_b), 32'd0);

      // Randomised files, selects (including the ignored one) and modes.
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 8; k++)
            wr(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 16'($urandom));
         v = 1'($urandom_range(0, 1));
         run(0, v, v ? 129 : 65, -1, 1'b0, 16'h0, "rnd_a");
         check("rnd_a_error", 32'(error_a), 32'd0);
      end
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 4; k++)
            wr(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 16'($urandom));
         v = 1'($urandom_range(0, 1));
         run(1, v, v ? 17 : 9, -1, 1'b0, 16'h0, "rnd_b");
         check("rnd_b_error", 32'(error_b), 32'd0);
      end

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/synapse_config_loader.md
Name: synapse_config_loader

Overview:
- Host-side controller that programs the serial configuration chain of N_SYN cascaded synapses.
- Holds a local parameter file (El, gl_jump, tau_gl per synapse) written by the host.
- On start, shifts the file into the chain head, producing its own cfg data clock from clk.
- Optional verify mode re-shifts the same stream and compares words returning at the chain tail against it.

Parameters:
N_SYN, 4, number of synapses in the chain (>=1)
WORD_WIDTH, 16, config word width (equals fp::WORD_LENGTH)
CLK_DIV, 2, cfg_data_clk half-period in clk cycles (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset==0 resets on posedge clk)
wr_en  in  1  parameter write strobe
wr_syn  in  $clog2(N_SYN) (min 1)  target synapse index
wr_sel  in  2  0=El, 1=gl_jump, 2=tau_gl, 3=ignored
wr_data  in  WORD_WIDTH  write data
start  in  1  begin programming (single-cycle pulse)
verify  in  1  sampled with start; 1 = program then verify pass
busy  out  1  programming in progress
done  out  1  one-cycle pulse at completion
error  out  1  sticky verify mismatch flag
mismatch_cnt  out  16  verify mismatches, saturating
cfg_data_clk  out  1  config shift clock to chain head
cfg_data_out  out  WORD_WIDTH  config data to chain head
cfg_data_in  in  WORD_WIDTH  config data from chain tail

Behaviour:
- Reset (reset==0): parameter file cleared to 0; state IDLE. Outputs: busy=0, done=0, error=0, mismatch_cnt=0, cfg_data_clk=0, cfg_data_out=0. Reset mid-stream aborts immediately; no further cfg_data_clk edges.
- Chain model: each synapse holds 4 stages, head to tail: El, gl_jump, tau_gl, pass register. Chain length L=4*N_SYN words.
- Stream order: word w (0..L-1) maps to syn = N_SYN-1-(w/4) and slot = 3-(w%4).
  - slot 3 sends 0 (dummy for the pass register).
  - slot 2 sends tau_gl, slot 1 sends gl_jump, slot 0 sends El.
  - The first word sent lands at the chain tail.
- Writes: accepted in IDLE only; wr_en while busy is dropped. wr_sel==3 or wr_syn>=N_SYN is a no-op.
  - wr_en and start in the same IDLE cycle: the write commits first and is included in the stream.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: start=1 -> LOW. Latch verify into pass_cnt_max (1 or 2 passes); w=0; pass=0; clear error and mismatch_cnt. busy=1 from the next cycle.
  - LOW: cfg_data_clk=0 and cfg_data_out=word(w) for CLK_DIV cycles, then -> HIGH.
    - Verify sample: in pass 1 (second pass) only, on the last LOW cycle, compare cfg_data_in with word(w).
    - On inequality: error<=1, mismatch_cnt++ (saturates at 16'hFFFF).
  - HIGH: cfg_data_clk=1 for CLK_DIV cycles; cfg_data_out stays word(w), stable across the rising edge.
    - At the end of HIGH: if w<L-1, increment w and go -> LOW.
    - Otherwise, if another pass remains: w=0, pass++, go -> LOW.
    - Otherwise -> DONE.
  - DONE: one cycle with done=1, busy=0, cfg_data_clk=0, then -> IDLE. cfg_data_out holds its last value.
- start while busy or in DONE: ignored.
- Timing:
  - Each word takes 2*CLK_DIV cycles; each pass takes L*2*CLK_DIV cycles.
  - done asserts 1 + passes*L*2*CLK_DIV cycles after the start cycle.
  - Exactly L rising cfg_data_clk edges are produced per pass.
- Verify rationale: after pass 0 the tail holds word 0. Before edge k of pass 1 the tail holds word k. Expected data is therefore regenerated from the file; no buffer is needed.
- error/mismatch_cnt persist until the next accepted start or reset.

Test Plan:
1. N_SYN=4, CLK_DIV=2. Write syn0..3 El=16'h0100+i, gl_jump=16'h0200+i, tau_gl=16'h0300+i. Pulse start, verify=0.
   -> 16 rising edges with word sequence 0,0303,0203,0103,0,0302,...,0100.
   -> done exactly 65 cycles after the start cycle; busy high for cycles 1..64.
2. Same file, verify=1, bench chain model (4 regs/synapse, clocked on cfg_data_clk, initially 0).
   -> model synapse registers hold the written values.
   -> error=0, mismatch_cnt=0, done at cycle 129.
3. Verify=1 with the model tail stuck at 16'hFFFF -> error=1, mismatch_cnt=16.
   - A following start with verify=0 -> error clears to 0 on acceptance.
4. While busy, pulse start and wr_en (syn0 El=16'hDEAD).
   -> no restart; file unchanged (a subsequent program shows 0100).
   - Same-cycle wr_en+start in IDLE -> the new value appears in the stream.
5. Assert reset=0 during pass 0 HIGH phase.
   -> next cycle: cfg_data_clk=0, busy=0, cfg_data_out=0, file reads back 0 on the next program.
6. CLK_DIV=1, N_SYN=1, verify=1.
   -> cfg_data_clk toggles every cycle, 4 edges per pass, done at cycle 17.
   - Write with wr_sel=3 -> no stream change.
